jtdsp16_rom_ctrl: RTL and testbench

JTDSP16_ROM_CTRL -- requirements
Module: jtdsp16_rom_ctrl

---
 rtl/jtdsp16_pkg.sv | 10 +
 rtl/jtdsp16_rom_ctrl_if.sv | 10 +
 rtl/jtdsp16_rom_tag.sv | 34 +++
 rtl/jtdsp16_rom_ctrl.sv | 91 +++++++++
 tb/tb_jtdsp16_rom_ctrl.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg: FSM encodings, address width, and the internal/external address test
package jtdsp16_pkg;
  localparam int INT_AW_DEF = 12;
  localparam int ADDR_W = 16;
  typedef logic [ADDR_W-1:0] addr_t;
  localparam logic [1:0] IDLE = 2'd0, PT_RQ = 2'd1, PC_RQ = 2'd2, GAP = 2'd3;
  function automatic logic is_ext(input addr_t a, input int aw);
    return (a >> aw) != '0;
  endfunction
endpackage

// File: rtl/jtdsp16_rom_ctrl_if.sv
// jtdsp16_rom_ctrl_if: external program-memory bus (level-held request, ok-qualified data)
interface jtdsp16_rom_ctrl_if;
  import jtdsp16_pkg::*;
  logic  ext_rq;
  addr_t ext_addr;
  logic [15:0] ext_data;
  logic  ext_ok;
  modport master(output ext_rq, ext_addr, input ext_data, ext_ok);
  modport slave(input ext_rq, ext_addr, output ext_data, ext_ok);
endinterface

// File: rtl/jtdsp16_rom_tag.sv
// jtdsp16_rom_tag: one-entry tag+data cache for a single requester
module jtdsp16_rom_tag
  import jtdsp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  addr_t       wr_addr,
  input  logic [15:0] wr_data,
  input  addr_t       rd_addr,
  output logic        hit,
  output logic [15:0] rd_data
);
  logic vld_q, vld_d;
  addr_t tag_q, tag_d;
  logic [15:0] dat_q, dat_d;
  always_comb begin
    vld_d = vld_q | we;
    tag_d = we ? wr_addr : tag_q;
    dat_d = we ? wr_data : dat_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      vld_q <= 1'b0;
      tag_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      dat_q <= dat_d;
    end
  assign hit = vld_q && tag_q == rd_addr;
  assign rd_data = dat_q;
endmodule

// File: rtl/jtdsp16_rom_ctrl.sv
// jtdsp16_rom_ctrl: serves PC/PT fetches above the internal ROM from external memory, stalling the DSP.
// Define JTDSP16_ROMCACHE_EN to add a one-entry cache per requester.
module jtdsp16_rom_ctrl
  import jtdsp16_pkg::*;
#(
  parameter int INT_AW = INT_AW_DEF,
  parameter int ROM_AW = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        prog_we,
  input  addr_t       pc_addr,
  input  logic        pc_rd,
  input  addr_t       pt,
  input  logic        pt_load,
  output logic        stall,
  output logic [15:0] pc_dout,
  output logic [15:0] pt_dout,
  jtdsp16_rom_ctrl_if.master ext
);
  localparam addr_t AMSK = ADDR_W'((17'd1 << ROM_AW) - 17'd1);
  logic [1:0] st_q, st_d;
  logic pend_q, pend_d;
  addr_t ext_addr_q, ext_addr_d, pend_addr_q, pend_addr_d;
  logic [15:0] pc_dout_q, pc_dout_d, pt_dout_q, pt_dout_d, pc_cdata, pt_cdata;
  logic pc_ext, pt_ext, pc_hit, pt_hit, pc_miss, pt_miss, cap_pc, cap_pt;
  assign pc_ext = cen && !prog_we && pc_rd && is_ext(pc_addr, INT_AW);
  assign pt_ext = cen && !prog_we && pt_load && is_ext(pt, INT_AW);
  assign pc_miss = st_q == IDLE && pc_ext && !pc_hit;
  assign pt_miss = st_q == IDLE && pt_ext && !pt_hit;
  assign cap_pc = st_q == PC_RQ && ext.ext_ok;
  assign cap_pt = st_q == PT_RQ && ext.ext_ok;
`ifdef JTDSP16_ROMCACHE_EN
  jtdsp16_rom_tag u_pc_tag (
    .clk(clk), .rst(rst), .we(cap_pc), .wr_addr(ext_addr_q), .wr_data(ext.ext_data),
    .rd_addr(pc_addr & AMSK), .hit(pc_hit), .rd_data(pc_cdata)
  );
  jtdsp16_rom_tag u_pt_tag (
    .clk(clk), .rst(rst), .we(cap_pt), .wr_addr(ext_addr_q), .wr_data(ext.ext_data),
    .rd_addr(pt & AMSK), .hit(pt_hit), .rd_data(pt_cdata)
  );
`else
  assign pc_hit = 1'b0;
  assign pt_hit = 1'b0;
  assign pc_cdata = pc_dout_q;
  assign pt_cdata = pt_dout_q;
`endif
  always_comb begin
    st_d = st_q;
    pend_d = pend_q;
    ext_addr_d = ext_addr_q;
    pend_addr_d = pend_addr_q;
    pc_dout_d = cap_pc ? ext.ext_data : pc_dout_q;
    pt_dout_d = cap_pt ? ext.ext_data : pt_dout_q;
    if (pt_miss || pc_miss) begin
      st_d = pt_miss ? PT_RQ : PC_RQ;
      ext_addr_d = (pt_miss ? pt : pc_addr) & AMSK;
      pend_d = pt_miss && pc_miss;
      pend_addr_d = pc_addr & AMSK;
    end else if (cap_pc || cap_pt) begin
      st_d = GAP;
    end else if (st_q == GAP) begin
      st_d = pend_q ? PC_RQ : IDLE;
      ext_addr_d = pend_q ? pend_addr_q : ext_addr_q;
      pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      st_q <= IDLE;
      pend_q <= 1'b0;
      ext_addr_q <= '0;
      pend_addr_q <= '0;
      pc_dout_q <= '0;
      pt_dout_q <= '0;
    end else begin
      st_q <= st_d;
      pend_q <= pend_d;
      ext_addr_q <= ext_addr_d;
      pend_addr_q <= pend_addr_d;
      pc_dout_q <= pc_dout_d;
      pt_dout_q <= pt_dout_d;
    end
  // GAP keeps the DSP frozen only if the simultaneous PC miss is still owed
  assign stall = !rst && (st_q == IDLE ? (pt_miss || pc_miss) : st_q == GAP ? pend_q : 1'b1);
  assign ext.ext_rq = st_q == PT_RQ || st_q == PC_RQ;
  assign ext.ext_addr = ext_addr_q;
  assign pc_dout = (pc_ext && pc_hit) ? pc_cdata : pc_dout_q;
  assign pt_dout = (pt_ext && pt_hit) ? pt_cdata : pt_dout_q;
endmodule

// File: tb/tb_jtdsp16_rom_ctrl.sv
// tb_jtdsp16_rom_ctrl: randomized transaction-level checks of the ROM controller
module tb_jtdsp16_rom_ctrl;
`ifdef JTDSP16_ROMCACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  logic clk = 0, rst = 1, cen = 0, prog_we = 0, pc_rd = 0, pt_load = 0, stall;
  logic [15:0] pc_addr = 0, pt = 0, pc_dout, pt_dout;
  logic [15:0] exp_pc = 0, exp_pt = 0, last_pc = 0, last_pt = 0;
  int total = 0, bad = 0;
  jtdsp16_rom_ctrl_if bus ();
  jtdsp16_rom_ctrl dut (
    .clk(clk), .rst(rst), .cen(cen), .prog_we(prog_we), .pc_addr(pc_addr), .pc_rd(pc_rd),
    .pt(pt), .pt_load(pt_load), .stall(stall), .pc_dout(pc_dout), .pt_dout(pt_dout), .ext(bus)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // One miss: stall from detection through the capture cycle, then a silent gap
  task automatic do_read(input bit is_pt, input logic [15:0] a, input logic [15:0] d, input int lat);
    int n = 0;
    cen = 1; pt_load = is_pt; pc_rd = !is_pt;
    pt = is_pt ? a : 16'h0; pc_addr = is_pt ? 16'h0 : a;
    #1 n += int'(stall);
    tick;
    pt_load = 0; pc_rd = 0;
    for (int c = 0; c <= lat; c++) begin
      bus.ext_ok = (c == lat);
      bus.ext_data = (c == lat) ? d : 16'($urandom);
      #1 n += int'(stall);
      total++;
      if (bus.ext_rq !== 1'b1 || bus.ext_addr !== a) begin
        bad++; $display("FAIL rd_req rq=%0b addr=%h expected rq=1 addr=%h", bus.ext_rq, bus.ext_addr, a);
      end
      tick;
    end
    bus.ext_ok = 0;
    if (is_pt) begin exp_pt = d; last_pt = a; end
    else begin exp_pc = d; last_pc = a; end
    #1 n += int'(stall);
    total++;
    if (bus.ext_rq !== 1'b0 || pt_dout !== exp_pt || pc_dout !== exp_pc) begin
      bad++; $display("FAIL rd_cap rq=%0b pt=%h pc=%h expected rq=0 pt=%h pc=%h", bus.ext_rq, pt_dout, pc_dout, exp_pt, exp_pc);
    end
    total++;
    if (n !== lat + 2) begin
      bad++; $display("FAIL rd_stall_cycles got=%0d expected=%0d", n, lat + 2);
    end
    tick;
  endtask
  task automatic test_reset;
    rst = 1; cen = 1; pt_load = 1; pt = 16'h8000;
    #1 total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b expected=0", stall); end
    tick; tick;
    total++;
    if (bus.ext_rq !== 1'b0 || bus.ext_addr !== 16'h0 || pc_dout !== 16'h0 || pt_dout !== 16'h0) begin
      bad++; $display("FAIL reset_state rq=%0b addr=%h pc=%h pt=%h expected all 0", bus.ext_rq, bus.ext_addr, pc_dout, pt_dout);
    end
    pt_load = 0; rst = 0;
    tick;
  endtask
  task automatic test_pt_read;
    do_read(1'b1, 16'h1234, 16'hBEEF, 2);
    total++;
    if (pt_dout !== 16'hBEEF) begin bad++; $display("FAIL pt_read got=%h expected=beef", pt_dout); end
  endtask
  task automatic test_both;
    logic [15:0] dpt = 16'($urandom), dpc = 16'($urandom);
    int lat = int'($urandom_range(0, 2));
    int n = 0;
    cen = 1; pc_rd = 1; pc_addr = 16'h2000; pt_load = 1; pt = 16'h3000;
    #1 n += int'(stall);
    tick;
    pc_rd = 0; pt_load = 0;
    for (int c = 0; c <= lat; c++) begin
      bus.ext_ok = (c == lat); bus.ext_data = dpt;
      #1 n += int'(stall);
      total++;
      if (bus.ext_rq !== 1'b1 || bus.ext_addr !== 16'h3000) begin
        bad++; $display("FAIL both_pt rq=%0b addr=%h expected rq=1 addr=3000", bus.ext_rq, bus.ext_addr);
      end
      tick;
    end
    bus.ext_ok = 0; exp_pt = dpt;
    #1 n += int'(stall);
    total++;
    if (bus.ext_rq !== 1'b0 || pt_dout !== exp_pt) begin
      bad++; $display("FAIL both_gap rq=%0b pt=%h expected rq=0 pt=%h", bus.ext_rq, pt_dout, exp_pt);
    end
    tick;
    bus.ext_ok = 1; bus.ext_data = dpc;
    #1 n += int'(stall);
    total++;
    if (bus.ext_rq !== 1'b1 || bus.ext_addr !== 16'h2000) begin
      bad++; $display("FAIL both_pc rq=%0b addr=%h expected rq=1 addr=2000", bus.ext_rq, bus.ext_addr);
    end
    tick;
    bus.ext_ok = 0; exp_pc = dpc;
    #1 total++;
    if (stall !== 1'b0 || bus.ext_rq !== 1'b0 || pc_dout !== exp_pc) begin
      bad++; $display("FAIL both_cap stall=%0b rq=%0b pc=%h expected 0 0 %h", stall, bus.ext_rq, pc_dout, exp_pc);
    end
    total++;
    if (n !== lat + 4) begin bad++; $display("FAIL both_stall_cycles got=%0d expected=%0d", n, lat + 4); end
    last_pt = 16'h3000; last_pc = 16'h2000;
    tick;
  endtask
  task automatic test_internal;
    cen = 1; pt_load = 1; pt = 16'h0FFF; pc_rd = 1; pc_addr = 16'h0ABC;
    #1 total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL int_stall got=%0b expected=0", stall); end
    tick;
    cen = 0; pt = 16'h9000; pc_addr = 16'hA000;
    #1 total++;
    if (stall !== 1'b0 || bus.ext_rq !== 1'b0) begin
      bad++; $display("FAIL int_nocen stall=%0b rq=%0b expected 0 0", stall, bus.ext_rq);
    end
    tick;
    pt_load = 0; pc_rd = 0; cen = 1;
    bus.ext_ok = 1; bus.ext_data = 16'($urandom);
    tick;
    bus.ext_ok = 0;
    #1 total++;
    if (bus.ext_rq !== 1'b0 || pt_dout !== exp_pt || pc_dout !== exp_pc) begin
      bad++; $display("FAIL idle_ok rq=%0b pt=%h pc=%h expected 0 %h %h", bus.ext_rq, pt_dout, pc_dout, exp_pt, exp_pc);
    end
  endtask
  task automatic test_prog_we;
    logic [15:0] d = 16'($urandom);
    prog_we = 1; cen = 1; pc_rd = 1; pc_addr = 16'h6000;
    #1 total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL pwe_stall got=%0b expected=0", stall); end
    tick;
    total++;
    if (bus.ext_rq !== 1'b0) begin bad++; $display("FAIL pwe_rq got=%0b expected=0", bus.ext_rq); end
    pc_rd = 0; prog_we = 0; pt_load = 1; pt = 16'h7000;
    tick;
    pt_load = 0; prog_we = 1;
    #1 total++;
    if (bus.ext_rq !== 1'b1 || stall !== 1'b1) begin
      bad++; $display("FAIL pwe_mid rq=%0b stall=%0b expected 1 1", bus.ext_rq, stall);
    end
    bus.ext_ok = 1; bus.ext_data = d;
    tick;
    bus.ext_ok = 0; exp_pt = d; last_pt = 16'h7000; prog_we = 0;
    #1 total++;
    if (pt_dout !== exp_pt) begin bad++; $display("FAIL pwe_cap got=%h expected=%h", pt_dout, exp_pt); end
    tick;
  endtask
  task automatic test_cache;
    logic [15:0] d1 = 16'($urandom), d2 = 16'($urandom);
    do_read(1'b1, 16'h5000, d1, 1);
    if (CACHE) begin
      cen = 1; pt_load = 1; pt = 16'h5000;
      #1 total++;
      if (stall !== 1'b0 || pt_dout !== d1) begin
        bad++; $display("FAIL cache_hit stall=%0b pt=%h expected 0 %h", stall, pt_dout, d1);
      end
      tick;
      pt_load = 0;
      #1 total++;
      if (bus.ext_rq !== 1'b0) begin bad++; $display("FAIL cache_rq got=%0b expected=0", bus.ext_rq); end
      tick;
    end else begin
      do_read(1'b1, 16'h5000, d2, 2);
    end
  endtask
  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      bit p = 1'($urandom);
      logic [15:0] a;
      do a = 16'($urandom_range(32'h1000, 32'hFFFF));
      while (CACHE && a == (p ? last_pt : last_pc));
      do_read(p, a, 16'($urandom), int'($urandom_range(0, 4)));
    end
  endtask
  task automatic test_reset_mid;
    rst = 1;
    tick;
    rst = 0; exp_pt = 0; exp_pc = 0; cen = 1; pt_load = 1; pt = 16'h4000;
    tick;
    pt_load = 0;
    #1 total++;
    if (bus.ext_rq !== 1'b1 || bus.ext_addr !== 16'h4000) begin
      bad++; $display("FAIL rmid_req rq=%0b addr=%h expected 1 4000", bus.ext_rq, bus.ext_addr);
    end
    rst = 1;
    tick;
    rst = 0;
    #1 total++;
    if (bus.ext_rq !== 1'b0) begin bad++; $display("FAIL rmid_drop got=%0b expected=0", bus.ext_rq); end
    bus.ext_ok = 1; bus.ext_data = 16'hABCD;
    tick;
    bus.ext_ok = 0;
    #1 total++;
    if (pt_dout !== 16'h0 || bus.ext_rq !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL rmid_late pt=%h rq=%0b stall=%0b expected 0 0 0", pt_dout, bus.ext_rq, stall);
    end
  endtask
  initial begin
    bus.ext_ok = 0; bus.ext_data = 0;
    test_reset;
    test_pt_read;
    test_both;
    test_internal;
    test_prog_we;
    test_cache;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
